execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Pipeline stage that consumes the ID/EX register outputs of the decode stage and produces the EX/MEM pipeline register.
- Performs forwarding-operand selection, the ALU operation, branch resolution (beq) and branch-target computation.
- Branch redirect (PCSrcE, PCTargetE) feeds back to the fetch stage.
- Registered results feed the memory stage and the forwarding network.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- RegWriteE  input  1  register-write enable from ID/EX
- ALUSrcE  input  1  1 selects Imm_Ext_E as ALU operand B
- MemWriteE  input  1  store enable
- ResultSrcE  input  1  1 = load result, 0 = ALU result
- BranchE  input  1  beq instruction
- ALUControlE  input  3  ALU operation
- RD1_E, RD2_E  input  XLEN  register operands
- Imm_Ext_E  input  XLEN  extended immediate
- RD_E  input  REGW  destination register
- PCE, PCPlus4E  input  XLEN  instruction PC and PC+4
- ForwardAE, ForwardBE  input  2  forwarding selects from hazard unit
- ResultW  input  XLEN  writeback-stage result
- StallM  input  1  hold EX/MEM register
- FlushM  input  1  insert bubble into EX/MEM
- PCSrcE  output  1  branch taken
- PCTargetE  output  XLEN  branch target
- RegWriteM, MemWriteM, ResultSrcM  output  1  registered controls
- RD_M  output  REGW  registered destination
- ALUResultM, WriteDataM, PCPlus4M  output  XLEN  registered data

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk. While rst=0, every EX/MEM output is 0 (controls, RD_M, ALUResultM, WriteDataM, PCPlus4M).
- PCSrcE and PCTargetE are combinational and are not affected by reset.
- Forwarding operand A (SrcAE) per ForwardAE:
  - 00 selects RD1_E.
  - 01 selects ResultW.
  - 10 selects ALUResultM (the registered output of this block).
  - 11 is treated as 00.
- Forwarding operand B (SrcBfwd) uses ForwardBE with the same encoding on RD2_E.
- SrcBE = ALUSrcE ? Imm_Ext_E : SrcBfwd.
- ALU, all XLEN-bit, wrap-around, no overflow flag:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt, signed: result is 1 or 0, zero-extended
  - any other code yields 0.
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
- EX/MEM register update on posedge clk, in priority order:
  1. FlushM=1: RegWriteM and MemWriteM go to 0 and ResultSrcM to 0; data fields capture normally. Flush has priority over stall.
  2. Else StallM=1: all EX/MEM fields hold.
  3. Else all fields capture: ALU result to ALUResultM, SrcBfwd to WriteDataM, RD_E to RD_M, PCPlus4E to PCPlus4M, controls from the E-side inputs.
- Latency: one cycle from E inputs to M outputs.
- Forward path 10 uses the current ALUResultM, so back-to-back dependent ALU ops resolve with zero bubbles.
- Reset asserted mid-operation clears the register immediately. The first capture after rst rises occurs on the next posedge.
- WriteDataM always holds the forwarded RD2 value, never the immediate, even when ALUSrcE=1.

Test Plan:
1. Reset: drive inputs nonzero, rst=0 → all M outputs 0 asynchronously, before any clock edge. Release rst → the next edge captures the inputs.
2. add/sub/slt:
   - RD1_E=5, RD2_E=7, ALUSrcE=0. ALUControlE=000 → ALUResultM=12. ALUControlE=001 → 0xFFFFFFFE.
   - RD1_E=0xFFFFFFFF, RD2_E=1, ALUControlE=101 → 1.
3. Forwarding: cycle 1 computes ALUResultM=12. Cycle 2 with ForwardAE=10, RD1_E=0, Imm_Ext_E=3, ALUSrcE=1, add → ALUResultM=15. Then ForwardBE=01, ResultW=9, ALUSrcE=1 → WriteDataM=9.
4. Branch: BranchE=1, RD1_E=RD2_E=4, sub, PCE=0x100, Imm_Ext_E=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0xF8. With RD2_E=5 → PCSrcE=0.
5. Stall/flush: StallM=1 for 2 cycles with changing inputs → M outputs constant. StallM=1 and FlushM=1 together → RegWriteM=0, MemWriteM=0 on the next edge.
6. Illegal ALUControlE=111, operands 0xAAAAAAAA and 0x55555555 → ALUResultM=0, and ZeroE makes PCSrcE=1 when BranchE=1.

Source files
------------

// File: rtl/execute_cycle_if.sv
// EX-stage bundle: ID/EX inputs, hazard-unit selects, branch redirect and EX/MEM outputs.
// The master side drives the E-side inputs; the slave side is the execute stage.
interface execute_cycle_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [REGW-1:0] RD_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            StallM;
  logic            FlushM;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [REGW-1:0] RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    output RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
    output ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
    input  ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    input  RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
    input  ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
    output ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution, branch target and the EX/MEM register.
// Branch redirect is combinational; the EX/MEM register resets asynchronously on rst low.
module execute_cycle #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic             clk,
  input  logic             rst,
  execute_cycle_if.slave   bus
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b_fwd;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  logic            r_reg_write_m;
  logic            r_mem_write_m;
  logic            r_result_src_m;
  logic [REGW-1:0] r_rd_m;
  logic [XLEN-1:0] r_alu_result_m;
  logic [XLEN-1:0] r_write_data_m;
  logic [XLEN-1:0] r_pc_plus4_m;

  // Select 10 loops back the registered result so dependent ops need no bubble.
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   w_src_a = bus.ResultW;
      2'b10:   w_src_a = r_alu_result_m;
      default: w_src_a = bus.RD1_E;
    endcase
  end

  always_comb begin
    case (bus.ForwardBE)
      2'b01:   w_src_b_fwd = bus.ResultW;
      2'b10:   w_src_b_fwd = r_alu_result_m;
      default: w_src_b_fwd = bus.RD2_E;
    endcase
  end

  assign w_src_b = bus.ALUSrcE ? bus.Imm_Ext_E : w_src_b_fwd;

  always_comb begin
    w_alu_result = '0;
    case (bus.ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b101:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero        = (w_alu_result == '0);
  assign bus.PCSrcE    = bus.BranchE & w_zero;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Flush beats stall: a flushed slot turns into a bubble even while memory is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 1'b0;
      r_rd_m         <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
    end else if (bus.FlushM || !bus.StallM) begin
      r_reg_write_m  <= bus.FlushM ? 1'b0 : bus.RegWriteE;
      r_mem_write_m  <= bus.FlushM ? 1'b0 : bus.MemWriteE;
      r_result_src_m <= bus.FlushM ? 1'b0 : bus.ResultSrcE;
      r_rd_m         <= bus.RD_E;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_src_b_fwd;
      r_pc_plus4_m   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ResultSrcM = r_result_src_m;
  assign bus.RD_M       = r_rd_m;
  assign bus.ALUResultM = r_alu_result_m;
  assign bus.WriteDataM = r_write_data_m;
  assign bus.PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed cases plus random traffic against a behavioural model.
module tb_execute_cycle;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_cycle_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  execute_cycle #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model of the EX/MEM register contents.
  logic        m_rw, m_mw, m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'd1) return bus.ResultW;
    if (sel == 2'd2) return m_alu;
    return rd;
  endfunction

  task automatic model_reset();
    m_rw = 0; m_mw = 0; m_rs = 0; m_rd = '0; m_alu = '0; m_wd = '0; m_pc4 = '0;
  endtask

  task automatic check_m(input string tag);
    check({tag, ".ctl"}, {29'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM},
          {29'd0, m_rw, m_mw, m_rs});
    check({tag, ".rd"},  {27'd0, bus.RD_M}, {27'd0, m_rd});
    check({tag, ".alu"}, bus.ALUResultM, m_alu);
    check({tag, ".wd"},  bus.WriteDataM, m_wd);
    check({tag, ".pc4"}, bus.PCPlus4M, m_pc4);
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step(input string tag);
    logic [31:0] a, bf, r;
    a  = fwd(bus.ForwardAE, bus.RD1_E);
    bf = fwd(bus.ForwardBE, bus.RD2_E);
    r  = ref_alu(bus.ALUControlE, a, bus.ALUSrcE ? bus.Imm_Ext_E : bf);
    #1;
    check({tag, ".pcsrc"}, {31'd0, bus.PCSrcE}, {31'd0, bus.BranchE && (r == 32'd0)});
    check({tag, ".tgt"}, bus.PCTargetE, bus.PCE + bus.Imm_Ext_E);
    @(posedge clk);
    if (bus.FlushM) begin
      m_rw = 0; m_mw = 0; m_rs = 0;
      m_rd = bus.RD_E; m_alu = r; m_wd = bf; m_pc4 = bus.PCPlus4E;
    end else if (!bus.StallM) begin
      m_rw = bus.RegWriteE; m_mw = bus.MemWriteE; m_rs = bus.ResultSrcE;
      m_rd = bus.RD_E; m_alu = r; m_wd = bf; m_pc4 = bus.PCPlus4E;
    end
    #1;
    check_m(tag);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.RegWriteE = 0; bus.ALUSrcE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.BranchE = 0; bus.ALUControlE = 3'd0; bus.RD1_E = '0; bus.RD2_E = '0;
    bus.Imm_Ext_E = '0; bus.RD_E = '0; bus.PCE = '0; bus.PCPlus4E = '0;
    bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0; bus.ResultW = '0;
    bus.StallM = 0; bus.FlushM = 0;
  endtask

  task automatic randomize_inputs(input bit allow_hazard);
    bus.RegWriteE   = 1'($urandom);
    bus.ALUSrcE     = 1'($urandom);
    bus.MemWriteE   = 1'($urandom);
    bus.ResultSrcE  = 1'($urandom);
    bus.BranchE     = 1'($urandom);
    bus.ALUControlE = 3'($urandom);
    bus.RD1_E       = $urandom;
    bus.RD2_E       = ($urandom_range(0, 3) == 0) ? bus.RD1_E : $urandom;
    bus.Imm_Ext_E   = $urandom;
    bus.RD_E        = 5'($urandom);
    bus.PCE         = $urandom;
    bus.PCPlus4E    = bus.PCE + 32'd4;
    bus.ForwardAE   = 2'($urandom);
    bus.ForwardBE   = 2'($urandom);
    bus.ResultW     = $urandom;
    bus.StallM      = allow_hazard && ($urandom_range(0, 4) == 0);
    bus.FlushM      = allow_hazard && ($urandom_range(0, 6) == 0);
  endtask

  logic [31:0] held_alu, held_wd;

  initial begin
    // Reset asserted with busy inputs: outputs must be zero before any edge.
    rst = 1'b0;
    randomize_inputs(1'b0);
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.ResultSrcE = 1; bus.RD_E = 5'd9;
    model_reset();
    #2;
    check_m("rst_async");
    @(negedge clk);
    @(negedge clk);
    check_m("rst_hold");
    rst = 1'b1;
    step("rst_release");

    // add / sub / slt
    clear_inputs();
    bus.RegWriteE = 1; bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.RD_E = 5'd3;
    step("add");
    check("add.lit", bus.ALUResultM, 32'd12);
    bus.ALUControlE = 3'b001;
    step("sub");
    check("sub.lit", bus.ALUResultM, 32'hFFFF_FFFE);
    bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1; bus.ALUControlE = 3'b101;
    step("slt");
    check("slt.lit", bus.ALUResultM, 32'd1);

    // Forwarding from ALUResultM and ResultW
    bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.ALUControlE = 3'b000;
    step("fwd_seed");
    bus.ForwardAE = 2'b10; bus.RD1_E = '0; bus.Imm_Ext_E = 32'd3; bus.ALUSrcE = 1;
    step("fwd_a");
    check("fwd_a.lit", bus.ALUResultM, 32'd15);
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b01; bus.ResultW = 32'd9;
    step("fwd_b");
    check("fwd_b.lit", bus.WriteDataM, 32'd9);

    // beq taken and not taken
    clear_inputs();
    bus.BranchE = 1; bus.RD1_E = 32'd4; bus.RD2_E = 32'd4; bus.ALUControlE = 3'b001;
    bus.PCE = 32'h100; bus.Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    check("beq.taken", {31'd0, bus.PCSrcE}, 32'd1);
    check("beq.tgt", bus.PCTargetE, 32'hF8);
    step("beq_t");
    bus.RD2_E = 32'd5;
    #1;
    check("beq.nt", {31'd0, bus.PCSrcE}, 32'd0);
    step("beq_nt");

    // Stall holds, flush overrides stall
    clear_inputs();
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.RD1_E = 32'd21; bus.RD2_E = 32'd33;
    step("pre_stall");
    held_alu = bus.ALUResultM;
    held_wd  = bus.WriteDataM;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs(1'b0);
      bus.StallM = 1;
      step("stall");
      check("stall.alu", bus.ALUResultM, held_alu);
      check("stall.wd", bus.WriteDataM, held_wd);
    end
    bus.StallM = 1; bus.FlushM = 1; bus.RegWriteE = 1; bus.MemWriteE = 1;
    step("flush");
    check("flush.ctl", {30'd0, bus.RegWriteM, bus.MemWriteM}, 32'd0);

    // Illegal op yields zero, which counts as equal for beq
    clear_inputs();
    bus.ALUControlE = 3'b111; bus.RD1_E = 32'hAAAA_AAAA; bus.RD2_E = 32'h5555_5555;
    bus.BranchE = 1;
    step("illegal");
    check("illegal.lit", bus.ALUResultM, 32'd0);

    // Random traffic with a mid-run reset
    for (int i = 0; i < 300; i++) begin
      randomize_inputs(1'b1);
      if (i == 150) begin
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_m("rst_mid");
        @(negedge clk);
        rst = 1'b1;
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
